// File: rtl/regex_cpu_windowed_pkg.sv
// Shared instruction encoding, thread record and core FSM states for the windowed regex core.
package instruction;

  localparam int OPCODE_WIDTH           = 3;
  localparam int INSTRUCTION_DATA_WIDTH = 13;
  localparam int THREAD_PC_WIDTH        = 8;
  localparam int THREAD_CC_ID_BITS      = 2;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    ACCEPT                = 3'd0,
    SPLIT                 = 3'd1,
    MATCH_CHAR            = 3'd2,
    NOT_MATCH             = 3'd3,
    MATCH_ANY             = 3'd4,
    JMP                   = 3'd5,
    END_WITHOUT_ACCEPTING = 3'd6,
    ACCEPT_PARTIAL        = 3'd7
  } opcode_e;

  // Thread record in the default core configuration; the core re-derives it from its own widths.
  typedef struct packed {
    logic [THREAD_PC_WIDTH-1:0]   pc;
    logic [THREAD_CC_ID_BITS-1:0] cc_id;
  } thread_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_EXEC
  } state_e;

endpackage

// File: rtl/regex_cpu_windowed_fifo.sv
// First-word-fall-through thread FIFO: two pushes and one pop per cycle, free-slot count out.
module thread_fifo
  import instruction::*;
#(
  parameter type T          = thread_t,
  parameter int  DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push0_i,
  input  T                    push0_data_i,
  input  logic                push1_i,
  input  T                    push1_data_i,
  input  logic                pop_i,
  output logic                empty_o,
  output T                    head_o,
  output logic [DEPTH_LOG2:0] free_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  T                      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q, wr_ptr1;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  pop_ok;

  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign free_o  = (DEPTH_LOG2+1)'(DEPTH) - count_q;
  assign wr_ptr1 = wr_ptr_q + DEPTH_LOG2'(1);

  // push1 always lands behind push0 so a SPLIT keeps pc+1 ahead of the branch target.
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
    if (push1_i) mem_q[wr_ptr1]  <= push1_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(pop_ok);
      wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(push0_i) + DEPTH_LOG2'(push1_i);
      count_q  <= count_q + (DEPTH_LOG2+1)'(push0_i) + (DEPTH_LOG2+1)'(push1_i)
                - (DEPTH_LOG2+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/regex_cpu_windowed.sv
// Regex execution core: fetch one instruction per thread, execute it against a character
// window lane, and queue up to two successor threads in the output FIFO.
module regex_cpu_windowed
  import instruction::*;
#(
  parameter int PC_WIDTH          = THREAD_PC_WIDTH,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int CC_ID_BITS        = THREAD_CC_ID_BITS,
  parameter int FIFO_DEPTH_LOG2   = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [(1<<CC_ID_BITS)*CHARACTER_WIDTH-1:0] current_characters,
  input  logic                                       input_pc_valid,
  output logic                                       input_pc_ready,
  input  logic [PC_WIDTH-1:0]                        input_pc,
  input  logic [CC_ID_BITS-1:0]                      input_cc_id,
  output logic                                       memory_valid,
  input  logic                                       memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]               memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                    memory_data,
  output logic                                       output_pc_valid,
  input  logic                                       output_pc_ready,
  output logic [PC_WIDTH-1:0]                        output_pc,
  output logic [CC_ID_BITS-1:0]                      output_cc_id,
  output logic                                       accepts,
  output logic [CC_ID_BITS-1:0]                      accepted_cc_id,
  output logic                                       running
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [CC_ID_BITS-1:0] cc_id;
  } thr_t;

  state_e                             state_q;
  logic [PC_WIDTH-1:0]                pc_q;
  logic [CC_ID_BITS-1:0]              cc_q;
  logic [MEMORY_WIDTH-1:0]            instr_q;
  logic                               mem_valid_q;
  logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr_q;
  logic                               accepts_q;
  logic [CC_ID_BITS-1:0]              acc_id_q;

  opcode_e                            op;
  logic [INSTRUCTION_DATA_WIDTH-1:0]  data;
  logic                               unused_data;
  logic [CHARACTER_WIDTH-1:0]         ch;
  logic [PC_WIDTH-1:0]                pc_inc;
  logic [CC_ID_BITS-1:0]              cc_inc;

  logic                               push0, push1, set_acc;
  thr_t                               push0_d, push1_d, head;
  logic                               fifo_empty;
  logic [FIFO_DEPTH_LOG2:0]           fifo_free;

  assign op          = opcode_e'(instr_q[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
  assign data        = instr_q[INSTRUCTION_DATA_WIDTH-1:0];
  assign unused_data = ^data;
  assign pc_inc      = pc_q + PC_WIDTH'(1);
  assign cc_inc      = cc_q + CC_ID_BITS'(1);

  always_comb ch = current_characters[int'(cc_q)*CHARACTER_WIDTH +: CHARACTER_WIDTH];

  always_comb begin
    push0   = 1'b0;
    push1   = 1'b0;
    set_acc = 1'b0;
    push0_d = '{pc: pc_inc, cc_id: cc_q};
    push1_d = '{pc: data[PC_WIDTH-1:0], cc_id: cc_q};
    if (state_q == S_EXEC) begin
      case (op)
        ACCEPT:         set_acc = (ch == '0);
        SPLIT:          begin push0 = 1'b1; push1 = 1'b1; end
        MATCH_CHAR:     begin push0 = (ch == data[CHARACTER_WIDTH-1:0]); push0_d.cc_id = cc_inc; end
        NOT_MATCH:      begin push0 = (ch != data[CHARACTER_WIDTH-1:0]); push0_d.cc_id = cc_inc; end
        MATCH_ANY:      begin push0 = 1'b1; push0_d.cc_id = cc_inc; end
        JMP:            begin push0 = 1'b1; push0_d.pc = data[PC_WIDTH-1:0]; end
        ACCEPT_PARTIAL: set_acc = 1'b1;
        default:        ;
      endcase
    end
  end

  // Two free slots are demanded up front so a SPLIT in EXEC can never overflow the FIFO.
  assign input_pc_ready = !rst && (state_q == S_IDLE) && (fifo_free >= (FIFO_DEPTH_LOG2+1)'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cc_q        <= '0;
      instr_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      accepts_q   <= 1'b0;
      acc_id_q    <= '0;
    end else begin
      if (set_acc && !accepts_q) begin
        accepts_q <= 1'b1;
        acc_id_q  <= cc_q;
      end
      case (state_q)
        S_IDLE: if (input_pc_valid && input_pc_ready) begin
          pc_q        <= input_pc;
          cc_q        <= input_cc_id;
          mem_addr_q  <= MEMORY_ADDR_WIDTH'(input_pc);
          mem_valid_q <= 1'b1;
          state_q     <= S_FETCH;
        end
        S_FETCH: if (memory_ready) begin
          mem_valid_q <= 1'b0;
          state_q     <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          instr_q <= memory_data;
          state_q <= S_EXEC;
        end
        S_EXEC:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  thread_fifo #(
    .T          (thr_t),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push0_i      (push0),
    .push0_data_i (push0_d),
    .push1_i      (push1),
    .push1_data_i (push1_d),
    .pop_i        (output_pc_ready),
    .empty_o      (fifo_empty),
    .head_o       (head),
    .free_o       (fifo_free)
  );

  assign memory_valid    = mem_valid_q;
  assign memory_addr     = mem_addr_q;
  assign output_pc_valid = !fifo_empty;
  assign output_pc       = fifo_empty ? '0 : head.pc;
  assign output_cc_id    = fifo_empty ? '0 : head.cc_id;
  assign accepts         = accepts_q;
  assign accepted_cc_id  = acc_id_q;
  assign running         = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_regex_cpu_windowed.sv
// Directed bench for regex_cpu_windowed with a behavioural instruction memory.
module tb_regex_cpu_windowed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cur_chars;
  logic        in_v, in_r;
  logic [7:0]  in_pc;
  logic [1:0]  in_cc;
  logic        mem_v, mem_r;
  logic [10:0] mem_a;
  logic [15:0] mem_d;
  logic        out_v, out_r;
  logic [7:0]  out_pc;
  logic [1:0]  out_cc;
  logic        acc;
  logic [1:0]  acc_id;
  logic        run;

  logic [15:0] imem [2048];
  logic [10:0] gnt_addr = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          lat;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_v && mem_r) gnt_addr <= mem_a;
  assign mem_d = imem[gnt_addr];

  regex_cpu_windowed dut (
    .clk                (clk),
    .rst                (rst),
    .current_characters (cur_chars),
    .input_pc_valid     (in_v),
    .input_pc_ready     (in_r),
    .input_pc           (in_pc),
    .input_cc_id        (in_cc),
    .memory_valid       (mem_v),
    .memory_ready       (mem_r),
    .memory_addr        (mem_a),
    .memory_data        (mem_d),
    .output_pc_valid    (out_v),
    .output_pc_ready    (out_r),
    .output_pc          (out_pc),
    .output_cc_id       (out_cc),
    .accepts            (acc),
    .accepted_cc_id     (acc_id),
    .running            (run)
  );

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [12:0] d);
    return {op, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the first negedge after the input handshake.
  task automatic send(input logic [7:0] pc, input logic [1:0] cc);
    int n = 0;
    while (!in_r && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", in_r, 1);
    in_v = 1'b1; in_pc = pc; in_cc = cc;
    @(negedge clk);
    in_v = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 1;
    while (!out_v && l < 20) begin @(negedge clk); l++; end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] pc, input logic [1:0] cc);
    chk({tag, "_v"},  out_v,  1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_cc"}, out_cc, cc);
    out_r = 1'b1;
    @(negedge clk);
    out_r = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) imem[i] = enc(3'd6, 13'd0);
    cur_chars = {8'h2E, 8'h2E, 8'h61, 8'h78};  // "xa.." lane0..3
    in_v = 1'b0; in_pc = '0; in_cc = '0; mem_r = 1'b1; out_r = 1'b0;

    // reset state
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_r, 0);
    chk("rst_mem_v", mem_v, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_out_v", out_v, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_cc", out_cc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_acc_id", acc_id, 0);
    chk("rst_run", run, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_r, 1);

    // JMP 0x2A at pc 5, lane 1
    imem[5] = enc(3'd5, 13'h2A);
    send(8'd5, 2'd1);
    chk("jmp_mem_v", mem_v, 1);
    chk("jmp_mem_a", mem_a, 5);
    wait_out(lat);
    chk("jmp_lat", lat, 4);
    chk("jmp_acc", acc, 0);
    chk("jmp_in_ready", in_r, 1);
    pop_chk("jmp", 8'h2A, 2'd1);
    chk("jmp_single", out_v, 0);
    chk("jmp_run_done", run, 0);

    // SPLIT D=0x10 at pc 7, lane 3, twice into a depth-4 FIFO
    imem[7] = enc(3'd1, 13'h10);
    send(8'd7, 2'd3);
    wait_out(lat);
    chk("split_lat", lat, 4);
    chk("split_head_pc", out_pc, 8);
    chk("split_half_ready", in_r, 1);
    send(8'd7, 2'd3);
    cyc(3);
    chk("split_full_ready", in_r, 0);
    chk("split_full_run", run, 1);
    cyc(2);
    chk("split_full_ready2", in_r, 0);
    pop_chk("split0", 8'd8, 2'd3);
    chk("split_free1_ready", in_r, 0);
    pop_chk("split1", 8'h10, 2'd3);
    chk("split_free2_ready", in_r, 1);
    pop_chk("split2", 8'd8, 2'd3);
    pop_chk("split3", 8'h10, 2'd3);
    chk("split_drained", out_v, 0);

    // MATCH_CHAR 'a'
    imem[20] = enc(3'd2, 13'h61);
    send(8'd20, 2'd1);
    wait_out(lat);
    chk("mc_lat", lat, 4);
    pop_chk("mc_hit", 8'd21, 2'd2);
    send(8'd20, 2'd0);
    cyc(2);
    chk("mc_miss_exec_run", run, 1);
    cyc(1);
    chk("mc_miss_out_v", out_v, 0);
    chk("mc_miss_run", run, 0);
    cur_chars = {8'h61, 8'h2E, 8'h61, 8'h78};
    send(8'd20, 2'd3);
    wait_out(lat);
    pop_chk("mc_wrap", 8'd21, 2'd0);

    // NOT_MATCH 'a'
    imem[30] = enc(3'd3, 13'h61);
    send(8'd30, 2'd0);
    wait_out(lat);
    pop_chk("nm_hit", 8'd31, 2'd1);
    send(8'd30, 2'd1);
    cyc(3);
    chk("nm_miss_out_v", out_v, 0);

    // MATCH_ANY at pc 255: pc and lane both wrap
    imem[255] = enc(3'd4, 13'h0);
    send(8'd255, 2'd3);
    wait_out(lat);
    pop_chk("any_wrap", 8'd0, 2'd0);

    // JMP with stalled grant; D truncates to pc width
    mem_r = 1'b0;
    imem[60] = enc(3'd5, 13'h1FF);
    send(8'd60, 2'd2);
    cyc(3);
    chk("stall_mem_v", mem_v, 1);
    chk("stall_mem_a", mem_a, 60);
    mem_r = 1'b1;
    cyc(1);
    chk("stall_mem_v_drop", mem_v, 0);
    cyc(1);
    chk("stall_exec_out_v", out_v, 0);
    cyc(1);
    pop_chk("stall_jmp", 8'hFF, 2'd2);

    // END_WITHOUT_ACCEPTING sweep
    for (int p = 0; p < 128; p++) imem[p] = enc(3'd6, 13'(p));
    for (int p = 0; p < 128; p++) begin
      for (int c = 0; c < 4; c++) begin
        send(8'(p), 2'(c));
        cyc(3);
        chk("end_out_v", out_v, 0);
        chk("end_in_ready", in_r, 1);
      end
    end
    chk("end_acc", acc, 0);

    // ACCEPT / ACCEPT_PARTIAL
    cur_chars = {8'h2E, 8'h00, 8'h61, 8'h78};
    imem[200] = enc(3'd0, 13'h0);
    imem[201] = enc(3'd7, 13'h0);
    send(8'd200, 2'd1);
    cyc(3);
    chk("acc_nonzero", acc, 0);
    send(8'd200, 2'd2);
    cyc(3);
    chk("acc_zero", acc, 1);
    chk("acc_zero_id", acc_id, 2);
    chk("acc_no_out", out_v, 0);
    send(8'd201, 2'd1);
    cyc(3);
    chk("accp_sticky", acc, 1);
    chk("accp_id_kept", acc_id, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("acc_rst", acc, 0);
    chk("acc_id_rst", acc_id, 0);
    rst = 1'b0;
    send(8'd201, 2'd3);
    cyc(3);
    chk("accp_first", acc, 1);
    chk("accp_first_id", acc_id, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // reset while awaiting a grant
    mem_r = 1'b0;
    imem[50] = enc(3'd5, 13'h33);
    send(8'd50, 2'd0);
    cyc(2);
    chk("midf_mem_v", mem_v, 1);
    chk("midf_mem_a", mem_a, 50);
    rst = 1'b1;
    @(negedge clk);
    chk("midf_rst_mem_v", mem_v, 0);
    chk("midf_rst_run", run, 0);
    chk("midf_rst_out_v", out_v, 0);
    rst = 1'b0;
    mem_r = 1'b1;
    cyc(5);
    chk("midf_late_out_v", out_v, 0);
    chk("midf_late_run", run, 0);

    // reset with a full FIFO
    imem[70] = enc(3'd1, 13'h44);
    send(8'd70, 2'd0);
    send(8'd70, 2'd0);
    cyc(3);
    chk("full_out_v", out_v, 1);
    chk("full_in_ready", in_r, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("full_rst_out_v", out_v, 0);
    chk("full_rst_run", run, 0);
    chk("full_rst_out_pc", out_pc, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("full_rst_in_ready", in_r, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
